// File: rtl/stream_gather_sipo_if.sv
// stream_gather_sipo_if: narrow beat stream in, wide single-beat message out.
interface stream_gather_sipo_if #(
    parameter int width_p = 64,
    parameter int max_els_p = 8,
    parameter int header_width_p = 32,
    parameter int lg_els_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1
);
    logic [header_width_p-1:0] header_i;
    logic [width_p-1:0] data_i;
    logic [lg_els_lp-1:0] len_i;
    logic v_i;
    logic ready_o;
    logic [header_width_p-1:0] header_o;
    logic [max_els_p*width_p-1:0] data_o;
    logic [lg_els_lp-1:0] len_o;
    logic v_o;
    logic yumi_i;

    modport master (
        output header_i, data_i, len_i, v_i, yumi_i,
        input ready_o, header_o, data_o, len_o, v_o
    );

    modport slave (
        input header_i, data_i, len_i, v_i, yumi_i,
        output ready_o, header_o, data_o, len_o, v_o
    );
endinterface

// File: rtl/stream_gather_sipo.sv
// stream_gather_sipo: gathers 1..max_els_p narrow beats plus a header into one wide message.
module stream_gather_sipo #(
    parameter int width_p = 64,
    parameter int max_els_p = 8,
    parameter int header_width_p = 32,
    localparam int lg_els_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1
) (
    input logic clk_i,
    input logic reset_i,
    stream_gather_sipo_if.slave bus
);
    localparam logic [lg_els_lp-1:0] last_lp = lg_els_lp'(max_els_p - 1);

    logic [lg_els_lp-1:0] cnt;
    logic [lg_els_lp-1:0] len_r;
    logic [lg_els_lp-1:0] len_c;
    logic [header_width_p-1:0] header_r;
    logic full;
    logic accept;
    logic [width_p-1:0] slots [max_els_p];

    assign len_c = (bus.len_i > last_lp) ? last_lp : bus.len_i;
    // full is a register, so ready has no path from v_i or yumi_i and never overlaps a yumi
    assign accept = bus.v_i & ~full;
    assign bus.ready_o = ~full;
    assign bus.v_o = full;
    assign bus.header_o = header_r;
    assign bus.len_o = len_r;

    for (genvar k = 0; k < max_els_p; k++) begin : g_out
        assign bus.data_o[k*width_p +: width_p] = slots[k];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
            len_r <= '0;
            header_r <= '0;
            full <= 1'b0;
            for (int i = 0; i < max_els_p; i++) slots[i] <= '0;
        end else begin
            if (bus.yumi_i & full) full <= 1'b0;
            if (accept) begin
                slots[cnt] <= bus.data_i;
                if (cnt == '0) begin
                    header_r <= bus.header_i;
                    len_r <= len_c;
                    if (len_c == '0) full <= 1'b1;
                    else cnt <= lg_els_lp'(1);
                end else if (cnt == len_r) begin
                    full <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_gather_sipo.sv
// tb_stream_gather_sipo: directed and random stimulus against a beat-list model of the gatherer.
module tb_stream_gather_sipo;
    localparam int W = 64;
    localparam int N = 8;
    localparam int H = 32;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_gather_sipo_if #(.width_p(W), .max_els_p(N), .header_width_p(H)) bus ();
    stream_gather_sipo #(.width_p(W), .max_els_p(N), .header_width_p(H)) dut (
        .clk_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_slots [N];
    bit m_full;
    logic [H-1:0] m_hdr;
    int m_len;
    int m_beats;

    task automatic check(input string n, input logic [511:0] a, input logic [511:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [511:0] m_data();
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = m_slots[k];
        return r;
    endfunction

    function automatic logic [511:0] flat(input logic [63:0] s7, s6, s5, s4, s3, s2, s1, s0);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    // Model: a message is the list of accepted beats; it completes once len+1 beats are in
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) m_slots[k] = '0;
            m_full = 1'b0;
            m_hdr = '0;
            m_len = 0;
            m_beats = 0;
        end else if (bus.yumi_i && m_full) begin
            m_full = 1'b0;
        end else if (bus.v_i && !m_full) begin
            if (m_beats == 0) begin
                m_hdr = bus.header_i;
                m_len = (int'(bus.len_i) > N - 1) ? N - 1 : int'(bus.len_i);
            end
            m_slots[m_beats] = bus.data_i;
            m_beats++;
            if (m_beats == m_len + 1) begin
                m_full = 1'b1;
                m_beats = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ready", 512'(bus.ready_o), 512'(!m_full));
            check("v", 512'(bus.v_o), 512'(m_full));
            if (m_full) begin
                check("header", 512'(bus.header_o), 512'(m_hdr));
                check("len", 512'(bus.len_o), 512'(m_len));
                check("data", bus.data_o, m_data());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [H-1:0] hdr, input int len, input int n,
                            input logic [63:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc = 1'b0;
            bus.header_i = (i == 0) ? hdr : ~hdr;
            bus.len_i = L'(len + i);
            bus.data_i = base + 64'(i);
            bus.v_i = 1'b1;
            for (int t = 0; t < 50 && !acc; t++) begin
                acc = bus.ready_o;
                tick();
            end
            check("send_timeout", 512'(acc), 512'(1));
            bus.v_i = 1'b0;
            if (i < n - 1) repeat (gap) tick();
        end
    endtask

    task automatic take();
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        check("ready_after_yumi", 512'(bus.ready_o), 512'(1));
    endtask

    initial begin
        logic [511:0] held;
        int idx;
        int cyc;
        bus.v_i = 1'b0;
        bus.yumi_i = 1'b0;
        bus.header_i = '0;
        bus.data_i = '0;
        bus.len_i = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready", 512'(bus.ready_o), 512'(1));
        check("rst_v", 512'(bus.v_o), 512'(0));
        check("rst_data", bus.data_o, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        send_msg(32'hCAFE0001, 7, 8, 64'h10, 0);
        check("full_v", 512'(bus.v_o), 512'(1));
        check("full_hdr", 512'(bus.header_o), 512'(32'hCAFE0001));
        check("full_len", 512'(bus.len_o), 512'(7));
        check("full_data", bus.data_o, flat(64'h17, 64'h16, 64'h15, 64'h14, 64'h13, 64'h12, 64'h11, 64'h10));
        repeat (2) tick();
        check("full_hold_ready", 512'(bus.ready_o), 512'(0));
        take();

        send_msg(32'h5, 0, 1, 64'hAA, 0);
        check("single_v", 512'(bus.v_o), 512'(1));
        check("single_len", 512'(bus.len_o), 512'(0));
        check("single_data", bus.data_o, flat(64'h17, 64'h16, 64'h15, 64'h14, 64'h13, 64'h12, 64'h11, 64'hAA));
        take();

        send_msg(32'h77, 1, 2, 64'h20, 0);
        held = flat(64'h17, 64'h16, 64'h15, 64'h14, 64'h13, 64'h12, 64'h21, 64'h20);
        bus.v_i = 1'b1;
        bus.data_i = 64'h99;
        bus.header_i = 32'h88;
        bus.len_i = '0;
        repeat (5) begin
            tick();
            check("bp_ready", 512'(bus.ready_o), 512'(0));
            check("bp_data", bus.data_o, held);
            check("bp_hdr", 512'(bus.header_o), 512'(32'h77));
        end
        take();
        tick();
        bus.v_i = 1'b0;
        check("bp_new_v", 512'(bus.v_o), 512'(1));
        check("bp_new_hdr", 512'(bus.header_o), 512'(32'h88));
        check("bp_new_data", bus.data_o, flat(64'h17, 64'h16, 64'h15, 64'h14, 64'h13, 64'h12, 64'h21, 64'h99));
        take();

        send_msg(32'hB0B, 3, 4, 64'h40, 2);
        check("bub_hdr", 512'(bus.header_o), 512'(32'hB0B));
        check("bub_len", 512'(bus.len_o), 512'(3));
        check("bub_data", bus.data_o, flat(64'h17, 64'h16, 64'h15, 64'h14, 64'h43, 64'h42, 64'h41, 64'h40));
        take();

        idx = 0;
        cyc = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            bit acc;
            bus.v_i = 1'b1;
            bus.data_i = 64'h50 + 64'(idx);
            bus.len_i = (idx < 2) ? L'(1) : L'(3);
            bus.header_i = (idx < 2) ? 32'hA : 32'hB;
            bus.yumi_i = bus.v_o;
            acc = bus.ready_o;
            tick();
            cyc++;
            if (acc) idx++;
        end
        bus.v_i = 1'b0;
        bus.yumi_i = 1'b0;
        check("b2b_beats", 512'(idx), 512'(6));
        check("b2b_cycles", 512'(cyc), 512'(7));
        check("b2b_hdr", 512'(bus.header_o), 512'(32'hB));
        check("b2b_data", bus.data_o, flat(64'h17, 64'h16, 64'h15, 64'h14, 64'h55, 64'h54, 64'h53, 64'h52));
        take();

        send_msg(32'h3, 2, 2, 64'h60, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 512'(bus.ready_o), 512'(1));
        check("mid_rst_v", 512'(bus.v_o), 512'(0));
        check("mid_rst_data", bus.data_o, '0);
        tick();
        rst = 1'b0;
        send_msg(32'h31, 1, 2, 64'h70, 0);
        check("post_rst_v", 512'(bus.v_o), 512'(1));
        check("post_rst_data", bus.data_o, flat(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h71, 64'h70));
        take();

        for (int c = 0; c < 3000; c++) begin
            bus.v_i = ($urandom % 4) != 0;
            bus.header_i = $urandom;
            bus.data_i = {$urandom, $urandom};
            bus.len_i = L'($urandom);
            bus.yumi_i = bus.v_o ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            tick();
        end
        bus.v_i = 1'b0;
        bus.yumi_i = 1'b0;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
